// File: rtl/uart_prog_pkg.sv
// Shared definitions for the UART program loader.
//  - prog_state_t : dialogue state of the loader
//  - msg_type_t   : which outgoing message the generator is producing
//  - tx_phase_t   : per-byte handshake phase toward uart_tx
//  - message lengths, fixed ASCII text fragments, hex_ascii() helper
package uart_prog_pkg;

  typedef enum logic [2:0] {
    ST_SEND_INIT = 3'd0,
    ST_RCV_SIZE  = 3'd1,
    ST_ECHO_SIZE = 3'd2,
    ST_RCV_DATA  = 3'd3,
    ST_SEND_DONE = 3'd4,
    ST_RCV_ADDR  = 3'd5,
    ST_FINISHED  = 3'd6
  } prog_state_t;

  typedef enum logic [1:0] {
    MSG_INIT = 2'd0,
    MSG_ECHO = 2'd1,
    MSG_DONE = 2'd2
  } msg_type_t;

  typedef enum logic [1:0] {
    TX_WAIT_IDLE = 2'd0,
    TX_STROBE    = 2'd1,
    TX_WAIT_DONE = 2'd2
  } tx_phase_t;

  localparam int INIT_MSG_LEN = 40;
  localparam int DONE_MSG_LEN = 57;
  localparam int ECHO_MSG_LEN = 4;

  // Text fragments; character 0 of each string sits in the most significant byte.
  localparam int INIT_PREFIX_LEN = 32;
  localparam int DONE_HEAD_LEN   = 17;
  localparam int DONE_MID_LEN    = 23;
  localparam logic [8*INIT_PREFIX_LEN-1:0] INIT_PREFIX = "ready for flash starting from 0x";
  localparam logic [8*DONE_HEAD_LEN-1:0]   DONE_HEAD   = "finished write 0x";
  localparam logic [8*DONE_MID_LEN-1:0]    DONE_MID    = " bytes starting from 0x";

  // Lowercase ASCII hex digit for a nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    logic [7:0] digit;
    if (nibble < 4'd10) begin
      digit = 8'h30 + {4'h0, nibble};
    end else begin
      digit = 8'h57 + {4'h0, nibble};
    end
    return digit;
  endfunction

endpackage

// File: rtl/uart_prog_msg_gen.sv
// Combinational ASCII generator for the loader's outgoing messages.
//  msg_type : MSG_INIT (40 B), MSG_ECHO (4 B size, MSB first), MSG_DONE (57 B)
//  idx      : byte index within the message
//  size     : received region size
//  addr     : current region start address
//  msg_byte : ASCII byte at position idx
module uart_prog_msg_gen
  import uart_prog_pkg::*;
(
  input  msg_type_t   msg_type,
  input  logic [5:0]  idx,
  input  logic [31:0] size,
  input  logic [31:0] addr,
  output logic [7:0]  msg_byte
);

  int i_s;
  assign i_s = int'(idx);

  // Nibble k of a word, k=0 being the most significant nibble.
  function automatic logic [3:0] nibble_at(input logic [31:0] w, input int k);
    return 4'(w >> (4 * (7 - k)));
  endfunction

  // Select the character for the current message position.
  always_comb begin
    msg_byte = 8'h00;
    case (msg_type)
      MSG_INIT: begin
        if (i_s < INIT_PREFIX_LEN) begin
          msg_byte = 8'(INIT_PREFIX >> (8 * (INIT_PREFIX_LEN - 1 - i_s)));
        end else begin
          msg_byte = hex_ascii(nibble_at(addr, i_s - INIT_PREFIX_LEN));
        end
      end
      MSG_ECHO: begin
        case (idx[1:0])
          2'd0:    msg_byte = size[31:24];
          2'd1:    msg_byte = size[23:16];
          2'd2:    msg_byte = size[15:8];
          default: msg_byte = size[7:0];
        endcase
      end
      MSG_DONE: begin
        // Layout: head(17) size-hex(8) mid(23) addr-hex(8) newline(1)
        if (i_s < DONE_HEAD_LEN) begin
          msg_byte = 8'(DONE_HEAD >> (8 * (DONE_HEAD_LEN - 1 - i_s)));
        end else if (i_s < DONE_HEAD_LEN + 8) begin
          msg_byte = hex_ascii(nibble_at(size, i_s - DONE_HEAD_LEN));
        end else if (i_s < DONE_HEAD_LEN + 8 + DONE_MID_LEN) begin
          msg_byte = 8'(DONE_MID >> (8 * (DONE_MID_LEN - 1 - (i_s - DONE_HEAD_LEN - 8))));
        end else if (i_s < DONE_MSG_LEN - 1) begin
          msg_byte = hex_ascii(nibble_at(addr, i_s - (DONE_HEAD_LEN + 8 + DONE_MID_LEN)));
        end else begin
          msg_byte = 8'h0a;
        end
      end
      default: msg_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: holds the core in reset, runs the flashing dialogue
// with the host over uart_rx/uart_tx, writes received bytes into memory and
// finally releases the core.
//  clk_i, rst_i (async, active-high)
//  rx_data_i/rx_valid_i           : bytes from uart_rx (no flow control)
//  tx_data_o/tx_valid_o/tx_busy_i : byte stream to uart_tx
//  mem_we_o/mem_addr_o/mem_be_o/mem_wdata_o : registered byte write port
//  core_reset_o                   : high until the terminating address 0 arrives
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int ADDR_W = 32
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_busy_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_reset_o
);

  localparam logic [ADDR_W-1:0] ZERO_W    = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_W     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(3);

  prog_state_t       state_r, state_s, after_send_s;
  tx_phase_t         phase_r, phase_s;
  msg_type_t         msg_type_s;
  logic [5:0]        idx_r, idx_s, msg_last_s;
  logic [ADDR_W-1:0] cnt_r, cnt_s;
  logic [ADDR_W-1:0] size_r, size_s;
  logic [ADDR_W-1:0] cur_addr_r, cur_addr_s;
  logic [ADDR_W-9:0] word_r, word_s;
  logic [ADDR_W-1:0] rx_word_s, data_addr_s;
  logic [7:0]        msg_byte_s;
  logic              tx_valid_r, tx_valid_s;
  logic [7:0]        tx_data_r, tx_data_s;
  logic              mem_we_r, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [3:0]        mem_be_r, mem_be_s;
  logic [31:0]       mem_wdata_r, mem_wdata_s;
  logic              core_reset_r, core_reset_s;

  uart_prog_msg_gen u_msg_gen (
    .msg_type (msg_type_s),
    .idx      (idx_r),
    .size     (size_r),
    .addr     (cur_addr_r),
    .msg_byte (msg_byte_s)
  );

  // Words arrive MSB first, so each new byte shifts in at the bottom.
  assign rx_word_s = {word_r, rx_data_i};
  // Data bytes arrive last-to-first: k-th byte lands at cur_addr+size-1-k.
  assign data_addr_s = cur_addr_r + size_r - ONE_W - cnt_r;

  // Message selection, length and follow-up state for the sending states.
  always_comb begin
    msg_type_s   = MSG_INIT;
    msg_last_s   = 6'(INIT_MSG_LEN - 1);
    after_send_s = ST_RCV_SIZE;
    case (state_r)
      ST_ECHO_SIZE: begin
        msg_type_s   = MSG_ECHO;
        msg_last_s   = 6'(ECHO_MSG_LEN - 1);
        after_send_s = (size_r == ZERO_W) ? ST_SEND_DONE : ST_RCV_DATA;
      end
      ST_SEND_DONE: begin
        msg_type_s   = MSG_DONE;
        msg_last_s   = 6'(DONE_MSG_LEN - 1);
        after_send_s = ST_RCV_ADDR;
      end
      default: begin
        msg_type_s   = MSG_INIT;
        msg_last_s   = 6'(INIT_MSG_LEN - 1);
        after_send_s = ST_RCV_SIZE;
      end
    endcase
  end

  // Next-state and next-output logic for the loader dialogue.
  always_comb begin
    state_s      = state_r;
    phase_s      = phase_r;
    idx_s        = idx_r;
    cnt_s        = cnt_r;
    size_s       = size_r;
    cur_addr_s   = cur_addr_r;
    word_s       = word_r;
    tx_valid_s   = 1'b0;
    tx_data_s    = tx_data_r;
    mem_we_s     = 1'b0;
    mem_addr_s   = ZERO_W;
    mem_be_s     = 4'b0000;
    mem_wdata_s  = 32'h0000_0000;
    core_reset_s = core_reset_r;
    case (state_r)
      ST_SEND_INIT, ST_ECHO_SIZE, ST_SEND_DONE: begin
        case (phase_r)
          TX_WAIT_IDLE: begin
            if (!tx_busy_i) begin
              tx_valid_s = 1'b1;
              tx_data_s  = msg_byte_s;
              phase_s    = TX_STROBE;
            end else begin
              phase_s = TX_WAIT_IDLE;
            end
          end
          // uart_tx raises busy one cycle after the strobe, so skip a cycle.
          TX_STROBE: phase_s = TX_WAIT_DONE;
          TX_WAIT_DONE: begin
            if (!tx_busy_i) begin
              phase_s = TX_WAIT_IDLE;
              if (idx_r == msg_last_s) begin
                idx_s   = 6'd0;
                cnt_s   = ZERO_W;
                state_s = after_send_s;
              end else begin
                idx_s = idx_r + 6'd1;
              end
            end else begin
              phase_s = TX_WAIT_DONE;
            end
          end
          default: phase_s = TX_WAIT_IDLE;
        endcase
      end
      ST_RCV_SIZE: begin
        if (rx_valid_i) begin
          word_s = rx_word_s[ADDR_W-9:0];
          if (cnt_r == LAST_BYTE) begin
            size_s  = rx_word_s;
            cnt_s   = ZERO_W;
            idx_s   = 6'd0;
            state_s = ST_ECHO_SIZE;
          end else begin
            cnt_s = cnt_r + ONE_W;
          end
        end else begin
          word_s = word_r;
        end
      end
      ST_RCV_DATA: begin
        if (rx_valid_i) begin
          mem_we_s    = 1'b1;
          mem_addr_s  = {data_addr_s[ADDR_W-1:2], 2'b00};
          mem_be_s    = 4'b0001 << data_addr_s[1:0];
          mem_wdata_s = {4{rx_data_i}};
          if (cnt_r == size_r - ONE_W) begin
            cnt_s   = ZERO_W;
            idx_s   = 6'd0;
            state_s = ST_SEND_DONE;
          end else begin
            cnt_s = cnt_r + ONE_W;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_RCV_ADDR: begin
        if (rx_valid_i) begin
          word_s = rx_word_s[ADDR_W-9:0];
          if (cnt_r == LAST_BYTE) begin
            cnt_s = ZERO_W;
            if (rx_word_s == ZERO_W) begin
              core_reset_s = 1'b0;
              state_s      = ST_FINISHED;
            end else begin
              cur_addr_s = rx_word_s;
              idx_s      = 6'd0;
              state_s    = ST_SEND_INIT;
            end
          end else begin
            cnt_s = cnt_r + ONE_W;
          end
        end else begin
          word_s = word_r;
        end
      end
      ST_FINISHED: core_reset_s = 1'b0;
      default: begin
        state_s = ST_SEND_INIT;
        phase_s = TX_WAIT_IDLE;
        idx_s   = 6'd0;
      end
    endcase
  end

  // State and output registers; async reset restarts the dialogue at address 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= ST_SEND_INIT;
      phase_r      <= TX_WAIT_IDLE;
      idx_r        <= 6'd0;
      cnt_r        <= ZERO_W;
      size_r       <= ZERO_W;
      cur_addr_r   <= ZERO_W;
      word_r       <= {(ADDR_W-8){1'b0}};
      tx_valid_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= ZERO_W;
      mem_be_r     <= 4'b0000;
      mem_wdata_r  <= 32'h0000_0000;
      core_reset_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      phase_r      <= phase_s;
      idx_r        <= idx_s;
      cnt_r        <= cnt_s;
      size_r       <= size_s;
      cur_addr_r   <= cur_addr_s;
      word_r       <= word_s;
      tx_valid_r   <= tx_valid_s;
      tx_data_r    <= tx_data_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_be_r     <= mem_be_s;
      mem_wdata_r  <= mem_wdata_s;
      core_reset_r <= core_reset_s;
    end
  end

  assign tx_data_o    = tx_data_r;
  assign tx_valid_o   = tx_valid_r;
  assign mem_we_o     = mem_we_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_be_o     = mem_be_r;
  assign mem_wdata_o  = mem_wdata_r;
  assign core_reset_o = core_reset_r;

endmodule
